// File: rtl/exec_branch_unit_pkg.sv
// exec_branch_unit_pkg: opcode constants, condition codes and flag ordering for the branch unit
package exec_branch_unit_pkg;
    localparam logic [5:0] OPC_BR_HI = 6'b001110;
    localparam logic [6:0] OPC_CALL  = 7'b0011110;
    localparam logic [6:0] OPC_RET   = 7'b0011111;
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_S = 2;
    localparam int FLG_V = 3;
    typedef logic [3:0] flags_t;
    typedef enum logic [3:0] {
        CC_AL, CC_Z, CC_NS, CC_S, CC_C, CC_V, CC_NZ, CC_NC,
        CC_NV, CC_LT, CC_GE, CC_LE, CC_GT, CC_LS, CC_HI, CC_NEVER
    } cond_e;
    // legacy (3-bit field) mode treats NZ/NC as never
    function automatic logic cond_eval(input cond_e cc, input flags_t f, input logic legacy);
        logic c, z, s, v, lt;
        c  = f[FLG_C];
        z  = f[FLG_Z];
        s  = f[FLG_S];
        v  = f[FLG_V];
        lt = s ^ v;
        case (cc)
            CC_AL:   cond_eval = 1'b1;
            CC_Z:    cond_eval = z;
            CC_NS:   cond_eval = ~s;
            CC_S:    cond_eval = s;
            CC_C:    cond_eval = c;
            CC_V:    cond_eval = v;
            CC_NZ:   cond_eval = ~legacy & ~z;
            CC_NC:   cond_eval = ~legacy & ~c;
            CC_NV:   cond_eval = ~v;
            CC_LT:   cond_eval = lt;
            CC_GE:   cond_eval = ~lt;
            CC_LE:   cond_eval = z | lt;
            CC_GT:   cond_eval = ~z & ~lt;
            CC_LS:   cond_eval = c | z;
            CC_HI:   cond_eval = ~c & ~z;
            default: cond_eval = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/exec_branch_unit_if.sv
// exec_branch_unit_if: execute-stage instruction inputs and fetch redirect / RAS status outputs
interface exec_branch_unit_if #(
    parameter int ADDR  = 16,
    parameter int W_OPR = 16,
    parameter int W_OPC = 7,
    parameter int CNT_W = 4
);
    logic             flush_i;
    logic             v_i;
    logic [ADDR-1:0]  pc_i;
    logic [W_OPC-1:0] opecode_i;
    logic [W_OPR-1:0] opr0_i;
    logic [W_OPR-1:0] opr1_i;
    logic             carry_flag_i;
    logic             zero_flag_i;
    logic             sign_flag_i;
    logic             overflow_flag_i;
    logic             branch_o;
    logic [ADDR-1:0]  branch_addr_o;
    logic             ras_ovf_o;
    logic             ras_unf_o;
    logic [CNT_W-1:0] ras_cnt_o;
    modport master (
        output flush_i, v_i, pc_i, opecode_i, opr0_i, opr1_i,
               carry_flag_i, zero_flag_i, sign_flag_i, overflow_flag_i,
        input  branch_o, branch_addr_o, ras_ovf_o, ras_unf_o, ras_cnt_o
    );
    modport slave (
        input  flush_i, v_i, pc_i, opecode_i, opr0_i, opr1_i,
               carry_flag_i, zero_flag_i, sign_flag_i, overflow_flag_i,
        output branch_o, branch_addr_o, ras_ovf_o, ras_unf_o, ras_cnt_o
    );
endinterface

// File: rtl/exec_branch_unit_ras.sv
// branch_ras: circular return-address stack with saturating count and overflow/underflow pulses
module branch_ras #(
    parameter int DEPTH = 8,
    parameter int W     = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_top,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf,
    output logic             o_unf
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             w_full;
    // r_ptr is the next write slot; when full it also holds the oldest entry
    assign w_full  = r_cnt == CNT_W'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_top   = r_mem[r_ptr - PW'(1)];
    assign o_cnt   = r_cnt;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= i_push & w_full;
            r_unf <= i_pop & o_empty;
            if (i_push) begin
                r_ptr <= r_ptr + PW'(1);
                r_cnt <= w_full ? r_cnt : r_cnt + CNT_W'(1);
            end else if (i_pop & ~o_empty) begin
                r_ptr <= r_ptr - PW'(1);
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_ptr] <= i_data;
    end
endmodule

// File: rtl/exec_branch_unit.sv
// exec_branch_unit: registered branch resolution with condition decode, CALL/RET via return-address stack
module exec_branch_unit
    import exec_branch_unit_pkg::*;
#(
    parameter int ADDR      = 16,
    parameter int W_OPR     = 16,
    parameter int W_OPC     = 7,
    parameter int COND_W    = 4,
    parameter int RAS_DEPTH = 8,
    parameter int INSN_STEP = 1
) (
    input logic clk,
    input logic rst,
    exec_branch_unit_if.slave bus
);
    logic            w_acc;
    logic            w_is_br;
    logic            w_is_call;
    logic            w_is_ret;
    logic            w_cond;
    logic            w_taken;
    logic            w_empty;
    logic            w_unused;
    logic [3:0]      w_cc;
    flags_t          w_flags;
    logic [ADDR-1:0] w_opr1;
    logic [ADDR-1:0] w_top;
    logic [ADDR-1:0] w_target;
    logic            r_branch;
    logic [ADDR-1:0] r_addr;
    assign w_acc     = bus.v_i & ~bus.flush_i;
    assign w_is_br   = bus.opecode_i[W_OPC-1:1] == OPC_BR_HI;
    assign w_is_call = bus.opecode_i == OPC_CALL;
    assign w_is_ret  = bus.opecode_i == OPC_RET;
    assign w_opr1    = bus.opr1_i[ADDR-1:0];
    assign w_cc      = 4'(bus.opr0_i[COND_W-1:0]);
    assign w_unused  = ^bus.opr0_i[W_OPR-1:COND_W];
    assign w_flags   = {bus.overflow_flag_i, bus.sign_flag_i, bus.zero_flag_i, bus.carry_flag_i};
    assign w_cond    = cond_eval(cond_e'(w_cc), w_flags, COND_W == 3);
    // RET on an empty stack does not redirect
    assign w_taken   = w_acc & (w_is_br & w_cond | w_is_call | w_is_ret & ~w_empty);
    assign w_target  = w_is_ret ? w_top
                     : (w_is_call | bus.opecode_i[0]) ? w_opr1
                     : bus.pc_i + w_opr1;
    branch_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_acc & w_is_call),
        .i_pop   (w_acc & w_is_ret),
        .i_data  (bus.pc_i + ADDR'(INSN_STEP)),
        .o_top   (w_top),
        .o_empty (w_empty),
        .o_cnt   (bus.ras_cnt_o),
        .o_ovf   (bus.ras_ovf_o),
        .o_unf   (bus.ras_unf_o)
    );
    always_ff @(posedge clk) begin
        r_branch <= rst ? 1'b0 : w_taken;
        r_addr   <= (rst | ~w_taken) ? '0 : w_target;
    end
    assign bus.branch_o      = r_branch;
    assign bus.branch_addr_o = r_addr;
endmodule

// File: tb/tb_exec_branch_unit.sv
// tb_exec_branch_unit: randomized and directed checks of exec_branch_unit against a queue-based reference model
module tb_exec_branch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exec_branch_unit_if #(.ADDR(16), .W_OPR(16), .W_OPC(7), .CNT_W(4)) bus ();
    exec_branch_unit_if #(.ADDR(16), .W_OPR(16), .W_OPC(7), .CNT_W(4)) bus3 ();

    exec_branch_unit #(.COND_W(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    exec_branch_unit #(.COND_W(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int n_chk = 0;
    int n_err = 0;
    string phase = "init";
    int unsigned ras_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
        end
    endtask

    function automatic bit ref_cond(input int cc, input bit c, input bit z, input bit s, input bit v, input bit legacy);
        if (legacy && cc >= 6) return 1'b0;
        case (cc)
            0: return 1'b1;
            1: return z;
            2: return !s;
            3: return s;
            4: return c;
            5: return v;
            6: return !z;
            7: return !c;
            8: return !v;
            9: return s != v;
            10: return s == v;
            11: return z || (s != v);
            12: return !z && (s == v);
            13: return c || z;
            14: return !c && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input bit v, input bit fl, input logic [15:0] pc, input logic [6:0] opc,
                         input logic [15:0] o0, input logic [15:0] o1, input logic [3:0] f);
        bus.v_i = v;  bus.flush_i = fl;  bus.pc_i = pc;  bus.opecode_i = opc;
        bus.opr0_i = o0;  bus.opr1_i = o1;
        bus.carry_flag_i = f[0];  bus.zero_flag_i = f[1];
        bus.sign_flag_i = f[2];   bus.overflow_flag_i = f[3];
        bus3.v_i = v; bus3.flush_i = fl; bus3.pc_i = pc; bus3.opecode_i = opc;
        bus3.opr0_i = o0; bus3.opr1_i = o1;
        bus3.carry_flag_i = f[0]; bus3.zero_flag_i = f[1];
        bus3.sign_flag_i = f[2];  bus3.overflow_flag_i = f[3];
    endtask

    task automatic check_outs(input bit e_br, input logic [15:0] e_addr, input bit e_ovf,
                              input bit e_unf, input bit e_br3);
        chk("branch", bus.branch_o, e_br);
        chk("addr", bus.branch_addr_o, e_addr);
        chk("ovf", bus.ras_ovf_o, e_ovf);
        chk("unf", bus.ras_unf_o, e_unf);
        chk("cnt", bus.ras_cnt_o, ras_q.size());
        chk("branch3", bus3.branch_o, e_br3);
    endtask

    task automatic apply(input bit v, input bit fl, input logic [15:0] pc, input logic [6:0] opc,
                         input logic [15:0] o0, input logic [15:0] o1, input logic [3:0] f);
        bit e_br, e_ovf, e_unf, e_br3;
        logic [15:0] e_addr;
        e_br = 0; e_ovf = 0; e_unf = 0; e_br3 = 0; e_addr = 16'h0;
        drive(v, fl, pc, opc, o0, o1, f);
        if (v && !fl) begin
            if (opc[6:1] == 6'b001110) begin
                e_br  = ref_cond(int'(o0[3:0]), f[0], f[1], f[2], f[3], 1'b0);
                e_br3 = ref_cond(int'(o0[2:0]), f[0], f[1], f[2], f[3], 1'b1);
                if (e_br) e_addr = opc[0] ? o1 : 16'(pc + o1);
            end else if (opc == 7'h1E) begin
                if (ras_q.size() == 8) begin
                    void'(ras_q.pop_front());
                    e_ovf = 1;
                end
                ras_q.push_back(32'(16'(pc + 16'd1)));
                e_br = 1; e_br3 = 1; e_addr = o1;
            end else if (opc == 7'h1F) begin
                if (ras_q.size() == 0) e_unf = 1;
                else begin
                    e_br = 1; e_br3 = 1; e_addr = 16'(ras_q.pop_back());
                end
            end
        end
        @(posedge clk);
        #1;
        check_outs(e_br, e_addr, e_ovf, e_unf, e_br3);
    endtask

    task automatic do_reset();
        drive(0, 0, 16'h0, 7'h0, 16'h0, 16'h0, 4'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ras_q.delete();
        check_outs(0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        phase = "reset";
        do_reset();

        phase = "br_rel";
        apply(1, 0, 16'h0100, 7'h1C, 16'h0000, 16'hFFF0, 4'h0);
        chk("addr_const", bus.branch_addr_o, 16'h00F0);
        phase = "br_abs";
        apply(1, 0, 16'h0100, 7'h1D, 16'h0000, 16'hFFF0, 4'h0);
        chk("addr_const", bus.branch_addr_o, 16'hFFF0);
        phase = "idle";
        apply(0, 0, 16'h0100, 7'h1D, 16'h0000, 16'hFFF0, 4'h0);

        phase = "cond_sweep";
        for (int cc = 0; cc < 16; cc++)
            for (int f = 0; f < 16; f++)
                apply(1, 0, 16'($urandom), 7'h1C | 7'($urandom_range(0, 1)),
                      {12'($urandom), 4'(cc)}, 16'($urandom), 4'(f));

        phase = "call_ret";
        apply(1, 0, 16'h0200, 7'h1E, 16'h0, 16'h4000, 4'h0);
        chk("cnt_const", bus.ras_cnt_o, 1);
        apply(1, 0, 16'h4000, 7'h1F, 16'h0, 16'h0, 4'h0);
        chk("addr_const", bus.branch_addr_o, 16'h0201);
        chk("cnt_const", bus.ras_cnt_o, 0);

        phase = "ras_ovf";
        for (int i = 0; i < 9; i++)
            apply(1, 0, 16'(16'h1000 + 16 * i), 7'h1E, 16'h0, 16'h8000, 4'h0);
        chk("ovf_const", bus.ras_ovf_o, 1);
        phase = "ras_lifo";
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 16'h8000, 7'h1F, 16'h0, 16'h0, 4'h0);
            chk("lifo_const", bus.branch_addr_o, 32'(16'h1000 + 16 * (8 - i) + 1));
        end
        phase = "ras_unf";
        apply(1, 0, 16'h8000, 7'h1F, 16'h0, 16'h0, 4'h0);
        chk("unf_const", bus.ras_unf_o, 1);

        phase = "flush";
        apply(1, 1, 16'h0300, 7'h1D, 16'h0, 16'h1234, 4'h0);
        apply(1, 0, 16'h0300, 7'h1D, 16'h0, 16'h1234, 4'h0);
        apply(1, 1, 16'h0300, 7'h1E, 16'h0, 16'h1234, 4'h0);
        apply(1, 1, 16'h0300, 7'h1F, 16'h0, 16'h1234, 4'h0);

        phase = "reset_mid";
        for (int i = 0; i < 3; i++)
            apply(1, 0, 16'(16'h2000 + i), 7'h1E, 16'h0, 16'h5000, 4'h0);
        do_reset();
        apply(1, 0, 16'h5000, 7'h1F, 16'h0, 16'h0, 4'h0);
        chk("unf_const", bus.ras_unf_o, 1);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] opc;
            int sel;
            sel = int'($urandom_range(0, 5));
            opc = sel == 0 ? 7'h1C : sel == 1 ? 7'h1D : sel == 2 ? 7'h1E
                : sel == 3 ? 7'h1F : 7'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            else apply($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 16'($urandom), opc,
                       16'($urandom), 16'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
